// File: rtl/csr_regfile_xlen.sv
// Machine-mode CSR file with XLEN-wide registers, 64-bit counters, trap/mret
// sequencing, prioritised interrupt requests and mtvec target generation.
module csr_regfile_xlen #(
   parameter int unsigned     XLEN        = 64,
   parameter logic [XLEN-1:0] HART_ID     = '0,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we_i,
   input  logic [1:0]      op_i,
   input  logic [11:0]     addr_i,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] data_o,
   output logic            illegal_o,
   input  logic            instret_i,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            mret_i,
   input  logic            irq_ext_i,
   input  logic            irq_sw_i,
   input  logic            irq_timer_i,
   output logic            irq_req_o,
   output logic [XLEN-1:0] irq_cause_o,
   output logic [XLEN-1:0] trap_vector_o,
   output logic [XLEN-1:0] mepc_o,
   output logic            global_int_en_o
);

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

   localparam bit              HAS_CNTH   = (XLEN == 32);
   localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(12'h888);
   localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);
   localparam logic [XLEN-1:0] MEPC_MASK  = ~XLEN'(1);
   localparam logic [XLEN-1:0] MTVEC_RST  = MTVEC_RESET & ~XLEN'(3);

   logic            mstatus_mie_q;
   logic            mstatus_mpie_q;
   logic [XLEN-1:0] mie_q;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mscratch_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;
   logic            mip_ext_q;
   logic            mip_sw_q;
   logic            mip_timer_q;
   logic [63:0]     mcycle_q;
   logic [63:0]     minstret_q;
   logic [63:0]     mcycle_d;
   logic [63:0]     minstret_d;

   logic [XLEN-1:0] csr_rdata;
   logic            csr_valid;
   logic            csr_ro;
   logic            wr_en;
   logic [XLEN-1:0] wr_val;
   logic [63:0]     wr64;

   logic            pend_ext;
   logic            pend_sw;
   logic            pend_timer;
   logic [3:0]      irq_code;
   logic [XLEN-1:0] mtvec_base;

   // Address decode and read mux; unimplemented addresses read as zero.
   always_comb begin
      csr_rdata = '0;
      csr_valid = 1'b1;
      csr_ro    = 1'b0;
      case (addr_i)
         ADDR_MSTATUS: begin
            csr_rdata[3]     = mstatus_mie_q;
            csr_rdata[7]     = mstatus_mpie_q;
            csr_rdata[12:11] = 2'b11;
         end
         ADDR_MIE:      csr_rdata = mie_q;
         ADDR_MTVEC:    csr_rdata = mtvec_q;
         ADDR_MSCRATCH: csr_rdata = mscratch_q;
         ADDR_MEPC:     csr_rdata = mepc_q;
         ADDR_MCAUSE:   csr_rdata = mcause_q;
         ADDR_MIP: begin
            csr_ro        = 1'b1;
            csr_rdata[3]  = mip_sw_q;
            csr_rdata[7]  = mip_timer_q;
            csr_rdata[11] = mip_ext_q;
         end
         ADDR_MCYCLE:   csr_rdata = XLEN'(mcycle_q);
         ADDR_MINSTRET: csr_rdata = XLEN'(minstret_q);
         ADDR_MCYCLEH: begin
            if (HAS_CNTH) csr_rdata = XLEN'(mcycle_q[63:32]);
            else          csr_valid = 1'b0;
         end
         ADDR_MINSTRETH: begin
            if (HAS_CNTH) csr_rdata = XLEN'(minstret_q[63:32]);
            else          csr_valid = 1'b0;
         end
         ADDR_MHARTID: begin
            csr_ro    = 1'b1;
            csr_rdata = HART_ID;
         end
         default: csr_valid = 1'b0;
      endcase
   end

   assign data_o    = csr_rdata;
   assign illegal_o = !csr_valid || (we_i && csr_ro);
   assign wr_en     = we_i && !illegal_o;

   // Read-modify-write value; the reserved op encoding behaves as a plain write.
   always_comb begin
      case (op_i)
         2'b01:   wr_val = csr_rdata | data_i;
         2'b10:   wr_val = csr_rdata & ~data_i;
         default: wr_val = data_i;
      endcase
   end

   // Counter next state: a write to either half replaces the whole increment.
   always_comb begin
      wr64       = 64'(wr_val);
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + 64'(instret_i);
      if (wr_en && addr_i == ADDR_MCYCLE)
         mcycle_d = HAS_CNTH ? {mcycle_q[63:32], wr64[31:0]} : wr64;
      if (wr_en && addr_i == ADDR_MCYCLEH)
         mcycle_d = {wr64[31:0], mcycle_q[31:0]};
      if (wr_en && addr_i == ADDR_MINSTRET)
         minstret_d = HAS_CNTH ? {minstret_q[63:32], wr64[31:0]} : wr64;
      if (wr_en && addr_i == ADDR_MINSTRETH)
         minstret_d = {wr64[31:0], minstret_q[31:0]};
   end

   // mstatus: trap entry beats mret, which beats a software write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
      end else if (trap_i) begin
         mstatus_mpie_q <= mstatus_mie_q;
         mstatus_mie_q  <= 1'b0;
      end else if (mret_i) begin
         mstatus_mie_q  <= mstatus_mpie_q;
         mstatus_mpie_q <= 1'b1;
      end else if (wr_en && addr_i == ADDR_MSTATUS) begin
         mstatus_mie_q  <= wr_val[3];
         mstatus_mpie_q <= wr_val[7];
      end
   end

   // mepc/mcause: trap entry overrides any software write in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mepc_q   <= '0;
         mcause_q <= '0;
      end else if (trap_i) begin
         mepc_q   <= trap_pc_i & MEPC_MASK;
         mcause_q <= trap_cause_i;
      end else begin
         if (wr_en && addr_i == ADDR_MEPC)   mepc_q   <= wr_val & MEPC_MASK;
         if (wr_en && addr_i == ADDR_MCAUSE) mcause_q <= wr_val;
      end
   end

   // Software-only CSRs, unaffected by trap or mret.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RST;
         mscratch_q <= '0;
      end else if (wr_en) begin
         if (addr_i == ADDR_MIE)      mie_q      <= wr_val & MIE_MASK;
         if (addr_i == ADDR_MTVEC)    mtvec_q    <= wr_val & MTVEC_MASK;
         if (addr_i == ADDR_MSCRATCH) mscratch_q <= wr_val;
      end
   end

   // Free-running 64-bit counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

   // Pending-interrupt register samples the level sources every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mip_ext_q   <= 1'b0;
         mip_sw_q    <= 1'b0;
         mip_timer_q <= 1'b0;
      end else begin
         mip_ext_q   <= irq_ext_i;
         mip_sw_q    <= irq_sw_i;
         mip_timer_q <= irq_timer_i;
      end
   end

   assign pend_ext   = mip_ext_q & mie_q[11];
   assign pend_sw    = mip_sw_q & mie_q[3];
   assign pend_timer = mip_timer_q & mie_q[7];
   assign irq_req_o  = mstatus_mie_q & (pend_ext | pend_sw | pend_timer);
   assign irq_code   = pend_ext ? 4'd11 : (pend_sw ? 4'd3 : 4'd7);

   // Interrupt cause: MSB set plus the winning code, zero when nothing is requested.
   always_comb begin
      irq_cause_o = '0;
      if (irq_req_o) begin
         irq_cause_o[XLEN-1] = 1'b1;
         irq_cause_o[3:0]    = irq_code;
      end
   end

   assign mtvec_base      = {mtvec_q[XLEN-1:2], 2'b00};
   assign trap_vector_o   = (mtvec_q[0] && irq_req_o) ?
                            mtvec_base + XLEN'({irq_code, 2'b00}) : mtvec_base;
   assign mepc_o          = mepc_q;
   assign global_int_en_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_regfile_xlen.sv
// Self-checking bench for csr_regfile_xlen (XLEN=32): directed literals plus
// randomized traffic compared every cycle against a behavioural model.
module tb_csr_regfile_xlen;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] HART = 32'd5;
   localparam logic [31:0] MTVR = 32'h0000_0103;
   typedef logic [XLEN-1:0] word_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we_i, instret_i, trap_i, mret_i;
   logic        irq_ext_i, irq_sw_i, irq_timer_i;
   logic [1:0]  op_i;
   logic [11:0] addr_i;
   word_t       data_i, trap_cause_i, trap_pc_i;
   word_t       data_o, irq_cause_o, trap_vector_o, mepc_o;
   logic        illegal_o, irq_req_o, global_int_en_o;

   always #5 clk = ~clk;

   csr_regfile_xlen #(.XLEN(XLEN), .HART_ID(HART), .MTVEC_RESET(MTVR)) dut (
      .clk(clk), .rst_n(rst_n), .we_i(we_i), .op_i(op_i), .addr_i(addr_i),
      .data_i(data_i), .data_o(data_o), .illegal_o(illegal_o),
      .instret_i(instret_i), .trap_i(trap_i), .trap_cause_i(trap_cause_i),
      .trap_pc_i(trap_pc_i), .mret_i(mret_i), .irq_ext_i(irq_ext_i),
      .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i), .irq_req_o(irq_req_o),
      .irq_cause_o(irq_cause_o), .trap_vector_o(trap_vector_o),
      .mepc_o(mepc_o), .global_int_en_o(global_int_en_o)
   );

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   // Architectural model state
   bit          m_mie, m_mpie, m_ext, m_sw, m_tim;
   word_t       m_mier, m_mtvec, m_scr, m_mepc, m_mcause;
   logic [63:0] m_cyc, m_ret;

   logic [11:0] pool [16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14,
                              12'h7C0, 12'h000, 12'h301, 12'h343};

   task automatic chk(input string name, input word_t act, input word_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_ext = 0; m_sw = 0; m_tim = 0;
      m_mier = '0; m_scr = '0; m_mepc = '0; m_mcause = '0;
      m_mtvec = MTVR & ~32'h3;
      m_cyc = '0; m_ret = '0;
   endtask

   task automatic mread(input logic [11:0] a, output word_t v, output bit ok, output bit ro);
      ok = 1; ro = 0; v = '0;
      case (a)
         12'h300: v = (word_t'(m_mie) << 3) | (word_t'(m_mpie) << 7) | 32'h1800;
         12'h304: v = m_mier;
         12'h305: v = m_mtvec;
         12'h340: v = m_scr;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'h344: begin ro = 1; v = (word_t'(m_ext) << 11) | (word_t'(m_sw) << 3) | (word_t'(m_tim) << 7); end
         12'hB00: v = m_cyc[31:0];
         12'hB02: v = m_ret[31:0];
         12'hB80: v = m_cyc[63:32];
         12'hB82: v = m_ret[63:32];
         12'hF14: begin ro = 1; v = HART; end
         default: ok = 0;
      endcase
   endtask

   task automatic mirq(output bit req, output word_t cause, output word_t vec);
      int code;
      bit any;
      any = 1; code = 0;
      if (m_ext && m_mier[11])     code = 11;
      else if (m_sw && m_mier[3])  code = 3;
      else if (m_tim && m_mier[7]) code = 7;
      else any = 0;
      req   = m_mie && any;
      cause = req ? (32'h8000_0000 | word_t'(code)) : '0;
      vec   = {m_mtvec[31:2], 2'b00} + ((m_mtvec[0] && req) ? word_t'(4 * code) : '0);
   endtask

   // One clock edge of the architectural model, using the inputs of the cycle.
   task automatic model_update();
      word_t old, nv;
      bit ok, ro, wr;
      bit n_mie, n_mpie;
      word_t n_mepc, n_mcause;
      logic [63:0] n_cyc, n_ret;
      mread(addr_i, old, ok, ro);
      wr = we_i && ok && !ro;
      case (op_i)
         2'b01:   nv = old | data_i;
         2'b10:   nv = old & ~data_i;
         default: nv = data_i;
      endcase
      n_mie = m_mie; n_mpie = m_mpie; n_mepc = m_mepc; n_mcause = m_mcause;
      n_cyc = m_cyc + 64'd1;
      n_ret = m_ret + 64'(instret_i);
      if (wr) begin
         case (addr_i)
            12'h300: if (!trap_i && !mret_i) begin n_mie = nv[3]; n_mpie = nv[7]; end
            12'h304: m_mier = nv & 32'h888;
            12'h305: m_mtvec = nv & ~32'h2;
            12'h340: m_scr = nv;
            12'h341: if (!trap_i) n_mepc = nv & ~32'h1;
            12'h342: if (!trap_i) n_mcause = nv;
            12'hB00: n_cyc = {m_cyc[63:32], nv};
            12'hB80: n_cyc = {nv, m_cyc[31:0]};
            12'hB02: n_ret = {m_ret[63:32], nv};
            12'hB82: n_ret = {nv, m_ret[31:0]};
            default: ;
         endcase
      end
      if (trap_i) begin
         n_mepc = trap_pc_i & ~32'h1; n_mcause = trap_cause_i;
         n_mpie = m_mie; n_mie = 0;
      end else if (mret_i) begin
         n_mie = m_mpie; n_mpie = 1;
      end
      m_mie = n_mie; m_mpie = n_mpie; m_mepc = n_mepc; m_mcause = n_mcause;
      m_cyc = n_cyc; m_ret = n_ret;
      m_ext = irq_ext_i; m_sw = irq_sw_i; m_tim = irq_timer_i;
   endtask

   // Compare every DUT output against the model in mid-cycle.
   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         word_t v, cause, vec;
         bit ok, ro, req;
         mread(addr_i, v, ok, ro);
         mirq(req, cause, vec);
         chk("data_o", data_o, v);
         chk("illegal_o", word_t'(illegal_o), word_t'(!ok || (we_i && ro)));
         chk("irq_req_o", word_t'(irq_req_o), word_t'(req));
         chk("irq_cause_o", irq_cause_o, cause);
         chk("trap_vector_o", trap_vector_o, vec);
         chk("mepc_o", mepc_o, m_mepc);
         chk("global_int_en_o", word_t'(global_int_en_o), word_t'(m_mie));
      end
   end

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_idle();
      we_i = 0; op_i = 2'b00; addr_i = 12'h000; data_i = '0;
      instret_i = 0; trap_i = 0; mret_i = 0; trap_cause_i = '0; trap_pc_i = '0;
      irq_ext_i = 0; irq_sw_i = 0; irq_timer_i = 0;
   endtask

   task automatic csr(input bit we, input logic [1:0] op, input logic [11:0] a, input word_t d);
      we_i = we; op_i = op; addr_i = a; data_i = d;
   endtask

   task automatic wr_chk(input string name, input logic [1:0] op, input logic [11:0] a,
                         input word_t d, input word_t old_exp);
      csr(1, op, a, d);
      #2 chk(name, data_o, old_exp);
      tick();
      we_i = 0;
   endtask

   task automatic rd_chk(input string name, input logic [11:0] a, input word_t exp);
      csr(0, 2'b00, a, '0);
      #2 chk(name, data_o, exp);
      tick();
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         we_i      = $urandom_range(0, 1);
         op_i      = 2'($urandom_range(0, 3));
         addr_i    = pool[$urandom_range(0, 15)];
         data_i    = $urandom;
         instret_i = $urandom_range(0, 1);
         trap_i    = ($urandom_range(0, 15) == 0);
         mret_i    = ($urandom_range(0, 15) == 0);
         trap_cause_i = $urandom;
         trap_pc_i    = $urandom;
         if ($urandom_range(0, 7) == 0) irq_ext_i   = ~irq_ext_i;
         if ($urandom_range(0, 7) == 0) irq_sw_i    = ~irq_sw_i;
         if ($urandom_range(0, 7) == 0) irq_timer_i = ~irq_timer_i;
         tick();
      end
   endtask

   initial begin
      set_idle();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_trap_vector", trap_vector_o, 32'h100);
      chk("rst_irq_req", word_t'(irq_req_o), '0);
      chk("rst_mepc", mepc_o, '0);
      #10;
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      tick();

      // Vectored mtvec with an external interrupt
      wr_chk("mtvec_old", 2'b00, 12'h305, 32'h8000_0001, 32'h100);
      rd_chk("mtvec_rd", 12'h305, 32'h8000_0001);
      wr_chk("mie_old", 2'b00, 12'h304, 32'h800, 32'h0);
      wr_chk("mstatus_old", 2'b00, 12'h300, 32'h8, 32'h1800);
      irq_ext_i = 1;
      tick();
      #2;
      chk("irq_req_ext", word_t'(irq_req_o), 32'h1);
      chk("irq_cause_ext", irq_cause_o, 32'h8000_000B);
      chk("trap_vec_ext", trap_vector_o, 32'h8000_002C);
      irq_ext_i = 0;
      tick();

      // Read-modify-write on mscratch
      wr_chk("scr_w", 2'b00, 12'h340, 32'hF0F0, 32'h0);
      wr_chk("scr_s", 2'b01, 12'h340, 32'h000F, 32'hF0F0);
      wr_chk("scr_c", 2'b10, 12'h340, 32'h00F0, 32'hF0FF);
      rd_chk("scr_rd", 12'h340, 32'hF00F);

      // Trap entry and mret
      set_idle();
      trap_i = 1; trap_pc_i = 32'h1235; trap_cause_i = 32'd2;
      tick();
      set_idle();
      #2;
      chk("trap_gie", word_t'(global_int_en_o), 32'h0);
      chk("trap_mepc_o", mepc_o, 32'h1234);
      rd_chk("trap_mepc", 12'h341, 32'h1234);
      rd_chk("trap_mcause", 12'h342, 32'd2);
      rd_chk("trap_mstatus", 12'h300, 32'h1880);
      mret_i = 1;
      tick();
      mret_i = 0;
      #2 chk("mret_gie", word_t'(global_int_en_o), 32'h1);
      rd_chk("mret_mstatus", 12'h300, 32'h1888);
      trap_i = 1; mret_i = 1; trap_pc_i = 32'h2000; trap_cause_i = 32'd5;
      csr(1, 2'b00, 12'h340, 32'h55);
      tick();
      set_idle();
      #2 chk("trapmret_gie", word_t'(global_int_en_o), 32'h0);
      rd_chk("trapmret_mstatus", 12'h300, 32'h1880);
      rd_chk("trapmret_scr", 12'h340, 32'h55);
      trap_i = 1; trap_pc_i = 32'h3001; trap_cause_i = 32'd7;
      csr(1, 2'b00, 12'h341, 32'h4444);
      tick();
      set_idle();
      rd_chk("trapwr_mepc", 12'h341, 32'h3000);

      // Counter halves and minstret stall
      wr_chk("cyc_lo_w", 2'b00, 12'hB00, 32'hFFFF_FFFF, m_cyc[31:0]);
      csr(1, 2'b00, 12'hB80, 32'h0);
      tick();
      rd_chk("cyc_lo_hold", 12'hB00, 32'hFFFF_FFFF);
      rd_chk("cyc_hi_carry", 12'hB80, 32'h1);
      wr_chk("ret_w", 2'b00, 12'hB02, 32'd7, m_ret[31:0]);
      repeat (3) tick();
      rd_chk("ret_stall", 12'hB02, 32'd7);
      instret_i = 1;
      tick();
      instret_i = 0;
      rd_chk("ret_inc", 12'hB02, 32'd8);

      // Read-only and unimplemented addresses
      csr(1, 2'b00, 12'hF14, 32'hFFFF);
      #2;
      chk("hart_wr_illegal", word_t'(illegal_o), 32'h1);
      chk("hart_wr_data", data_o, HART);
      tick();
      rd_chk("hart_rd", 12'hF14, HART);
      csr(0, 2'b00, 12'h7C0, '0);
      #2;
      chk("unimpl_illegal", word_t'(illegal_o), 32'h1);
      chk("unimpl_data", data_o, 32'h0);
      tick();
      irq_sw_i = 1;
      tick();
      csr(1, 2'b01, 12'h344, 32'hFFFF);
      #2;
      chk("mip_wr_illegal", word_t'(illegal_o), 32'h1);
      chk("mip_wr_data", data_o, 32'h8);
      tick();
      set_idle();

      rand_cycles(1500);

      // Asynchronous reset with an interrupt pending
      set_idle();
      csr(1, 2'b00, 12'h304, 32'h800);
      tick();
      csr(1, 2'b00, 12'h300, 32'h8);
      irq_ext_i = 1;
      tick();
      we_i = 0;
      tick();
      #1 chk("pre_rst_irq", word_t'(irq_req_o), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_irq_req", word_t'(irq_req_o), 32'h0);
      chk("arst_irq_cause", irq_cause_o, 32'h0);
      chk("arst_gie", word_t'(global_int_en_o), 32'h0);
      chk("arst_mepc", mepc_o, 32'h0);
      chk("arst_trap_vector", trap_vector_o, 32'h100);
      model_reset();
      set_idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      rd_chk("post_rst_mie", 12'h304, 32'h0);

      rand_cycles(300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
